// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the default frame width
// used by uart_rx, uart_tx and uart_tx_arbiter.
package uart_pkg;

  localparam int unsigned DataWidthDefault = 8;

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    Issue    = 2'd1,
    WaitBusy = 2'd2,
    WaitDone = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: the first set request at or above the pointer, wrapping
// modulo NumReq. The scan wraps explicitly, so NumReq need not be a power of two.
module rr_pick #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic                found_o,
  output logic [IdxWidth-1:0] idx_o
);

  int unsigned cand;

  // Scanning from the farthest offset down to offset 0 lets the nearest request win.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      cand = int'(ptr_i) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (req_i[IdxWidth'(cand)]) begin
        found_o = 1'b1;
        idx_o   = IdxWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NumReq byte producers, with round-robin
// selection and an optional per-requester lock for multi-byte messages.
//
// state    | meaning
// Idle     | pick a winner (locked owner only, if locked), accept its byte
// Issue    | one-cycle tx_start_o pulse with the latched byte
// WaitBusy | wait for the transmitter to raise busy (unbounded)
// WaitDone | wait for busy to fall, then update the lock and the pointer
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = DataWidthDefault
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  input  logic [NumReq-1:0]           req_lock_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic [NumReq-1:0]           grant_o,
  output logic                        tx_start_o,
  output logic [DataWidth-1:0]        tx_data_o,
  input  logic                        tx_busy_i,
  output logic                        active_o
);

  localparam int unsigned IdxWidth = $clog2(NumReq);

  arb_state_e           state_q, state_d;
  logic [IdxWidth-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0]  owner_q, owner_d;
  logic                 lock_q, lock_d;
  logic [DataWidth-1:0] tx_data_q, tx_data_d;

  logic [NumReq-1:0]    owner_oh;
  logic [NumReq-1:0]    eligible;
  logic                 pick_found;
  logic [IdxWidth-1:0]  pick_idx;

  assign owner_oh = NumReq'(1) << owner_q;
  assign eligible = lock_q ? (req_valid_i & owner_oh) : req_valid_i;

  rr_pick #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_rr_pick (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    lock_d      = lock_q;
    tx_data_d   = tx_data_q;
    req_ready_o = '0;
    tx_start_o  = 1'b0;
    grant_o     = owner_oh;
    case (state_q)
      Idle: begin
        grant_o = lock_q ? owner_oh : '0;
        if (pick_found) begin
          req_ready_o = NumReq'(1) << pick_idx;
          owner_d     = pick_idx;
          tx_data_d   = req_data_i[pick_idx*DataWidth +: DataWidth];
          state_d     = Issue;
        end
      end
      Issue: begin
        tx_start_o = 1'b1;
        state_d    = WaitBusy;
      end
      WaitBusy: begin
        if (tx_busy_i) state_d = WaitDone;
      end
      WaitDone: begin
        if (!tx_busy_i) begin
          state_d = Idle;
          if (req_lock_i[owner_q]) begin
            lock_d = 1'b1;
          end else begin
            lock_d   = 1'b0;
            rr_ptr_d = (owner_q == IdxWidth'(NumReq - 1)) ? '0 : owner_q + IdxWidth'(1);
          end
        end
      end
      default: state_d = Idle;
    endcase
    // A byte is not consumed while reset is held, so never advertise acceptance.
    if (rst_i) req_ready_o = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      lock_q    <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_data_o = tx_data_q;
  assign active_o  = (state_q != Idle);

endmodule
